// File: rtl/issue_select.sv
// issue_select: picks up to two eligible buffer entries per cycle, oldest first, under per-cycle class limits
// Ports: clk; reset (async, active low); entries (buffer contents, index 0 oldest); flush (squash);
// issue_valid/tag/index/unit/mode per slot (registered); div_busy (divider occupied).
package issue_select_pkg;
  localparam int IDX_W = 4;
  typedef logic [IDX_W:0] tag_t;
  typedef logic [IDX_W-1:0] index_t;
  typedef enum logic [2:0] {S_NOT_USED, S_NOT_EXECUTED, S_ADDR_GENERATED, S_EXECUTING, S_EXECUTED} e_state_t;
  typedef enum logic [2:0] {U_ALU, U_BRANCH, U_MUL, U_DIV, U_LOAD, U_STORE} unit_t;
  typedef enum logic {EX_NORMAL, EX_GEN_ADDR} ex_mode_t;
  typedef struct packed {
    e_state_t e_state;
    logic J_rdy;
    logic K_rdy;
    unit_t Unit;
    tag_t tag;
    logic [IDX_W:0] number_of_early_store_ops;
  } entry_t;
endpackage

module issue_select import issue_select_pkg::*; #(
  parameter int BUF_SIZE_LOG = IDX_W,
  parameter int DIV_CYCLES = 34
) (
  input  logic clk,
  input  logic reset,
  input  entry_t entries [2**BUF_SIZE_LOG],
  input  logic flush,
  output logic [1:0] issue_valid,
  output tag_t issue_tag [2],
  output index_t issue_index [2],
  output unit_t issue_unit [2],
  output ex_mode_t issue_mode [2],
  output logic div_busy
);
  localparam int N = 2**BUF_SIZE_LOG;
  localparam int CW = $clog2(DIV_CYCLES+1);
  localparam logic [2:0] C_NONE = 3'd0, C_BR = 3'd1, C_MUL = 3'd2, C_LDM = 3'd3, C_DIV = 3'd4;
  logic [CW-1:0] div_cnt, cnt_nx;
  logic [N-1:0] elig, ne, ldm, gen, nrm, msk;
  logic [2:0] cls [N];
  ex_mode_t mode [N];
  logic f0, f1, div_iss, div_free;
  index_t s0, s1;
  // a DIV may be picked while the counter sits at 1, since it reaches 0 on the same edge that registers the new DIV
  assign div_free = div_cnt <= CW'(1);
  always_comb begin
    elig = '0;
    ne = '0;
    ldm = '0;
    gen = '0;
    nrm = '0;
    msk = '0;
    for (int i = 0; i < N; i++) begin
      ne[i] = entries[i].e_state == S_NOT_EXECUTED;
      msk[i] = (issue_valid[0] && entries[i].tag[BUF_SIZE_LOG-1:0] == issue_tag[0][BUF_SIZE_LOG-1:0]) ||
               (issue_valid[1] && entries[i].tag[BUF_SIZE_LOG-1:0] == issue_tag[1][BUF_SIZE_LOG-1:0]);
      ldm[i] = entries[i].Unit == U_LOAD && entries[i].e_state == S_ADDR_GENERATED &&
               entries[i].number_of_early_store_ops == '0;
      gen[i] = ne[i] && ((entries[i].Unit == U_LOAD && entries[i].J_rdy) ||
               (entries[i].Unit == U_STORE && entries[i].J_rdy && entries[i].K_rdy));
      nrm[i] = ne[i] && entries[i].J_rdy && entries[i].K_rdy &&
               (entries[i].Unit inside {U_ALU, U_BRANCH, U_MUL} || (entries[i].Unit == U_DIV && div_free));
      elig[i] = !msk[i] && (gen[i] || nrm[i] || ldm[i]);
      mode[i] = gen[i] ? EX_GEN_ADDR : EX_NORMAL;
      cls[i] = ldm[i] ? C_LDM :
               entries[i].Unit == U_BRANCH ? C_BR :
               entries[i].Unit == U_MUL ? C_MUL :
               entries[i].Unit == U_DIV ? C_DIV : C_NONE;
    end
  end
  always_comb begin
    f0 = 1'b0;
    f1 = 1'b0;
    s0 = '0;
    s1 = '0;
    for (int i = 0; i < N; i++) begin
      if (elig[i]) begin
        if (!f0) begin
          f0 = 1'b1;
          s0 = index_t'(i);
        end else if (!f1 && !(cls[i] != C_NONE && cls[i] == cls[s0])) begin
          f1 = 1'b1;
          s1 = index_t'(i);
        end
      end
    end
    div_iss = (f0 && cls[s0] == C_DIV) || (f1 && cls[s1] == C_DIV);
    cnt_nx = flush ? '0 : div_iss ? CW'(DIV_CYCLES) : div_cnt != '0 ? div_cnt - 1'b1 : '0;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issue_valid <= 2'b00;
      issue_tag[0] <= '0;
      issue_tag[1] <= '0;
      issue_index[0] <= '0;
      issue_index[1] <= '0;
      issue_unit[0] <= U_ALU;
      issue_unit[1] <= U_ALU;
      issue_mode[0] <= EX_NORMAL;
      issue_mode[1] <= EX_NORMAL;
      div_cnt <= '0;
      div_busy <= 1'b0;
    end else begin
      issue_valid <= flush ? 2'b00 : {f1, f0};
      issue_tag[0] <= entries[s0].tag;
      issue_tag[1] <= entries[s1].tag;
      issue_index[0] <= s0;
      issue_index[1] <= s1;
      issue_unit[0] <= entries[s0].Unit;
      issue_unit[1] <= entries[s1].Unit;
      issue_mode[0] <= mode[s0];
      issue_mode[1] <= mode[s1];
      div_cnt <= cnt_nx;
      div_busy <= cnt_nx != '0;
    end
  end
endmodule

// File: tb/tb_issue_select.sv
// tb_issue_select: directed scoreboard bench for issue_select
module tb_issue_select;
  import issue_select_pkg::*;
  typedef struct {
    int cyc;
    logic [1:0] v;
    int i0;
    int i1;
    unit_t u0;
    unit_t u1;
    ex_mode_t m0;
    ex_mode_t m1;
    logic busy;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  entry_t entries [16];
  logic [1:0] issue_valid;
  tag_t issue_tag [2];
  index_t issue_index [2];
  unit_t issue_unit [2];
  ex_mode_t issue_mode [2];
  logic div_busy;
  exp_t q [$];
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  issue_select #(.BUF_SIZE_LOG(4), .DIV_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .entries(entries), .flush(flush),
    .issue_valid(issue_valid), .issue_tag(issue_tag), .issue_index(issue_index),
    .issue_unit(issue_unit), .issue_mode(issue_mode), .div_busy(div_busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic tag_t tg(input int i);
    return tag_t'(i + 8);
  endfunction
  task automatic clear_all();
    for (int i = 0; i < 16; i++)
      entries[i] = '{e_state: S_NOT_USED, J_rdy: 1'b1, K_rdy: 1'b1, Unit: U_ALU, tag: tg(i), number_of_early_store_ops: '0};
  endtask
  task automatic set_e(input int i, input e_state_t s, input unit_t u, input logic j, input logic k, input int early);
    entries[i] = '{e_state: s, J_rdy: j, K_rdy: k, Unit: u, tag: tg(i), number_of_early_store_ops: 5'(early)};
  endtask
  task automatic step(input logic [1:0] v, input int i0, input unit_t u0, input ex_mode_t m0,
                      input int i1, input unit_t u1, input ex_mode_t m1, input logic busy);
    exp_t e;
    e.cyc = cyc + 1;
    e.v = v;
    e.i0 = i0;
    e.i1 = i1;
    e.u0 = u0;
    e.u1 = u1;
    e.m0 = m0;
    e.m1 = m1;
    e.busy = busy;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input logic busy);
    step(2'b00, 0, U_ALU, EX_NORMAL, 0, U_ALU, EX_NORMAL, busy);
  endtask
  task automatic chk_slot(input int k, input int c, input int idx, input unit_t u, input ex_mode_t m);
    n_cmp++;
    if (issue_index[k] !== index_t'(idx) || issue_tag[k] !== tg(idx) || issue_unit[k] !== u || issue_mode[k] !== m) begin
      n_bad++;
      $display("FAIL slot%0d cyc=%0d got idx=%0d tag=%0d unit=%0d mode=%0d exp idx=%0d tag=%0d unit=%0d mode=%0d",
               k, c, issue_index[k], issue_tag[k], issue_unit[k], issue_mode[k], idx, tg(idx), u, m);
    end
  endtask
  task automatic chk_zero(input string name);
    n_cmp++;
    if (issue_valid !== 2'b00 || div_busy !== 1'b0 || issue_tag[0] !== '0 || issue_tag[1] !== '0 ||
        issue_index[0] !== '0 || issue_index[1] !== '0 || issue_unit[0] !== U_ALU || issue_unit[1] !== U_ALU ||
        issue_mode[0] !== EX_NORMAL || issue_mode[1] !== EX_NORMAL) begin
      n_bad++;
      $display("FAIL %s got valid=%b busy=%b tag0=%0d idx0=%0d exp all zero", name, issue_valid, div_busy, issue_tag[0], issue_index[0]);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL missed check for cyc=%0d", e.cyc);
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      n_cmp++;
      if (issue_valid !== e.v) begin
        n_bad++;
        $display("FAIL valid cyc=%0d got=%b exp=%b", cyc, issue_valid, e.v);
      end
      n_cmp++;
      if (div_busy !== e.busy) begin
        n_bad++;
        $display("FAIL div_busy cyc=%0d got=%b exp=%b", cyc, div_busy, e.busy);
      end
      if (e.v[0]) chk_slot(0, cyc, e.i0, e.u0, e.m0);
      if (e.v[1]) chk_slot(1, cyc, e.i1, e.u1, e.m1);
    end
  end
  initial begin
    clear_all();
    #1 reset = 1'b0;
    #1 chk_zero("reset_init");
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    // two ALUs, then the mask window, then buffer marks them executing
    set_e(2, S_NOT_EXECUTED, U_ALU, 1, 1, 0);
    set_e(5, S_NOT_EXECUTED, U_ALU, 1, 1, 0);
    step(2'b11, 2, U_ALU, EX_NORMAL, 5, U_ALU, EX_NORMAL, 0);
    idle(0);
    entries[2].e_state = S_EXECUTING;
    entries[5].e_state = S_EXECUTING;
    idle(0);
    // branch limit: second branch skipped, younger ALU takes slot 1
    clear_all();
    set_e(0, S_NOT_EXECUTED, U_BRANCH, 1, 1, 0);
    set_e(1, S_NOT_EXECUTED, U_BRANCH, 1, 1, 0);
    set_e(3, S_NOT_EXECUTED, U_ALU, 1, 1, 0);
    step(2'b11, 0, U_BRANCH, EX_NORMAL, 3, U_ALU, EX_NORMAL, 0);
    entries[0].e_state = S_EXECUTING;
    entries[3].e_state = S_EXECUTING;
    step(2'b01, 1, U_BRANCH, EX_NORMAL, 0, U_ALU, EX_NORMAL, 0);
    entries[1].e_state = S_EXECUTING;
    idle(0);
    // divider occupancy with DIV_CYCLES=4, then flush at div_cnt=3
    clear_all();
    set_e(0, S_NOT_EXECUTED, U_DIV, 1, 1, 0);
    set_e(1, S_NOT_EXECUTED, U_DIV, 1, 1, 0);
    step(2'b01, 0, U_DIV, EX_NORMAL, 0, U_ALU, EX_NORMAL, 1);
    entries[0].e_state = S_EXECUTING;
    idle(1);
    idle(1);
    idle(1);
    step(2'b01, 1, U_DIV, EX_NORMAL, 0, U_ALU, EX_NORMAL, 1);
    entries[1].e_state = S_EXECUTING;
    set_e(2, S_NOT_EXECUTED, U_ALU, 1, 1, 0);
    set_e(3, S_NOT_EXECUTED, U_ALU, 1, 1, 0);
    step(2'b11, 2, U_ALU, EX_NORMAL, 3, U_ALU, EX_NORMAL, 1);
    entries[2].e_state = S_EXECUTING;
    entries[3].e_state = S_EXECUTING;
    set_e(4, S_NOT_EXECUTED, U_ALU, 1, 1, 0);
    set_e(5, S_NOT_EXECUTED, U_ALU, 1, 1, 0);
    flush = 1'b1;
    idle(0);
    flush = 1'b0;
    step(2'b11, 4, U_ALU, EX_NORMAL, 5, U_ALU, EX_NORMAL, 0);
    clear_all();
    idle(0);
    // load gating on early stores, then address generation modes
    set_e(4, S_ADDR_GENERATED, U_LOAD, 1, 1, 1);
    idle(0);
    set_e(4, S_ADDR_GENERATED, U_LOAD, 1, 1, 0);
    step(2'b01, 4, U_LOAD, EX_NORMAL, 0, U_ALU, EX_NORMAL, 0);
    entries[4].e_state = S_EXECUTED;
    set_e(5, S_NOT_EXECUTED, U_STORE, 1, 0, 0);
    set_e(6, S_NOT_EXECUTED, U_LOAD, 1, 0, 0);
    step(2'b01, 6, U_LOAD, EX_GEN_ADDR, 0, U_ALU, EX_NORMAL, 0);
    clear_all();
    idle(0);
    // one load memory access per cycle; store address generation is unrestricted
    set_e(0, S_ADDR_GENERATED, U_LOAD, 1, 1, 0);
    set_e(1, S_ADDR_GENERATED, U_LOAD, 1, 1, 0);
    set_e(2, S_NOT_EXECUTED, U_STORE, 1, 1, 0);
    step(2'b11, 0, U_LOAD, EX_NORMAL, 2, U_STORE, EX_GEN_ADDR, 0);
    clear_all();
    idle(0);
    // mul limit, divide alongside, then countdown to idle
    set_e(1, S_NOT_EXECUTED, U_MUL, 1, 1, 0);
    set_e(2, S_NOT_EXECUTED, U_MUL, 1, 1, 0);
    set_e(5, S_NOT_EXECUTED, U_DIV, 1, 1, 0);
    step(2'b11, 1, U_MUL, EX_NORMAL, 5, U_DIV, EX_NORMAL, 1);
    clear_all();
    idle(1);
    idle(1);
    idle(1);
    idle(0);
    // asynchronous reset mid-divide
    set_e(0, S_NOT_EXECUTED, U_DIV, 1, 1, 0);
    set_e(1, S_NOT_EXECUTED, U_ALU, 1, 1, 0);
    step(2'b11, 0, U_DIV, EX_NORMAL, 1, U_ALU, EX_NORMAL, 1);
    @(negedge clk);
    #1 reset = 1'b0;
    clear_all();
    set_e(3, S_NOT_EXECUTED, U_DIV, 1, 1, 0);
    #1 chk_zero("reset_async");
    #1 reset = 1'b1;
    step(2'b01, 3, U_DIV, EX_NORMAL, 0, U_ALU, EX_NORMAL, 1);
    clear_all();
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_cmp += q.size();
      n_bad += q.size();
      $display("FAIL scoreboard_drain pending=%0d exp=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
